// File: rtl/mux4_rr_sel.sv
// Round-robin select generator for a 4:1 two-bit data mux.
// It grants one producer at a time for a bounded burst and forwards valid/ready between it and the consumer.
module mux4_rr_sel #(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] in_valid,
    input  logic       out_ready,
    output logic [1:0] sel,
    output logic [3:0] grant,
    output logic       out_valid,
    output logic [3:0] in_ready,
    output logic       busy
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] LOCK = 1'b1;
    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST);

    logic [0:0] state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] beat_q, beat_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] gidx_q, gidx_d;

    logic       isLock;
    logic       curValid;
    logic       xfer;
    logic       relNow;
    logic [3:0] beatInc;
    logic [1:0] searchPtr;
    logic [1:0] probeIdx;
    logic       winFound;
    logic [1:0] winIdx;

    // On release the search starts just past the current owner, so that owner is naturally probed last.
    always_comb begin
        isLock    = (state_q == LOCK);
        curValid  = in_valid[gidx_q];
        xfer      = isLock && curValid && out_ready;
        beatInc   = beat_q + 4'd1;
        relNow    = isLock && (!curValid || (xfer && (beatInc == BURST_LAST)));
        searchPtr = relNow ? (gidx_q + 2'd1) : ptr_q;

        winFound = 1'b0;
        winIdx   = 2'd0;
        probeIdx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            probeIdx = searchPtr + 2'(i);
            if (!winFound && in_valid[probeIdx]) begin
                winFound = 1'b1;
                winIdx   = probeIdx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        beat_d  = beat_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        gidx_d  = gidx_q;

        if (!isLock) begin
            if (winFound) begin
                state_d = LOCK;
                grant_d = 4'b0001 << winIdx;
                sel_d   = 2'd3 - winIdx;
                gidx_d  = winIdx;
                beat_d  = 4'd0;
            end
        end else if (relNow) begin
            ptr_d = gidx_q + 2'd1;
            if (winFound) begin
                grant_d = 4'b0001 << winIdx;
                sel_d   = 2'd3 - winIdx;
                gidx_d  = winIdx;
                beat_d  = 4'd0;
            end else begin
                state_d = IDLE;
                grant_d = 4'b0000;
            end
        end else if (xfer) begin
            beat_d = beatInc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            beat_q  <= 4'd0;
            grant_q <= 4'b0000;
            sel_q   <= 2'b11;
            gidx_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            gidx_q  <= gidx_d;
        end
    end

    // grant_q is zero outside LOCK, so masking by it also gates the handshake while idle.
    assign sel       = sel_q;
    assign grant     = grant_q;
    assign busy      = isLock;
    assign out_valid = isLock && curValid;
    assign in_ready  = isLock ? (grant_q & {4{out_ready}}) : 4'b0000;

endmodule

// File: tb/tb_mux4_rr_sel.sv
// Scoreboard bench for mux4_rr_sel: expected granted channel per transfer is queued when stimulus is driven.
module tb_mux4_rr_sel;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] inValid = 4'b0000;
    logic       outReady = 1'b0;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       outValid;
    logic [3:0] inReady;
    logic       busy;

    logic [3:0] inValid1 = 4'b0000;
    logic       outReady1 = 1'b0;
    logic [1:0] sel1;
    logic [3:0] grant1;
    logic       outValid1;
    logic [3:0] inReady1;
    logic       busy1;

    int nErrors = 0;
    int nChecks = 0;
    logic [3:0] expQ[$];
    logic [3:0] expQ1[$];
    logic [3:0] expA;
    logic [3:0] expB;

    mux4_rr_sel #(.MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid), .out_ready(outReady),
        .sel(sel), .grant(grant), .out_valid(outValid), .in_ready(inReady), .busy(busy)
    );

    mux4_rr_sel #(.MAX_BURST(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid1), .out_ready(outReady1),
        .sel(sel1), .grant(grant1), .out_valid(outValid1), .in_ready(inReady1), .busy(busy1)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [1:0] selOf(input logic [3:0] g);
        case (g)
            4'b0001: return 2'b11;
            4'b0010: return 2'b10;
            4'b0100: return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] iv, input logic ordy);
        inValid  = iv;
        outReady = ordy;
    endtask

    task automatic pushExp(input logic [3:0] g, input int n);
        for (int i = 0; i < n; i++) expQ.push_back(g);
    endtask

    task automatic applyReset();
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("rstGrant", 32'(grant), 0);
        checkOutput("rstSel", 32'(sel), 3);
        checkOutput("rstBusy", 32'(busy), 0);
        checkOutput("rstOutValid", 32'(outValid), 0);
        checkOutput("rstInReady", 32'(inReady), 0);
        tick();
        rst_n = 1'b1;
    endtask

    // Every accepted word is matched against the next queued channel for its instance.
    always @(negedge clk) begin
        if (rst_n && outValid && outReady) begin
            if (expQ.size() == 0) begin
                checkOutput("xferQueueDepth", 32'(expQ.size()), 1);
            end else begin
                expA = expQ.pop_front();
                checkOutput("xferGrant", 32'(grant), 32'(expA));
                checkOutput("xferSel", 32'(sel), 32'(selOf(expA)));
                checkOutput("xferInReady", 32'(inReady), 32'(expA));
            end
        end
        if (rst_n && outValid1 && outReady1) begin
            if (expQ1.size() == 0) begin
                checkOutput("xfer1QueueDepth", 32'(expQ1.size()), 1);
            end else begin
                expB = expQ1.pop_front();
                checkOutput("xfer1Grant", 32'(grant1), 32'(expB));
                checkOutput("xfer1Sel", 32'(sel1), 32'(selOf(expB)));
            end
        end
    end

    initial begin
        $display("[TB] start");

        // Single requester: two back-to-back bursts of channel 2, then idle.
        applyReset();
        applyStimulus(4'b0100, 1'b1);
        pushExp(4'b0100, 5);
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            checkOutput("singleBusy", 32'(busy), 1);
            checkOutput("singleBeat", 32'(dut.beat_q), 32'(i % 4));
        end
        tick();
        applyStimulus(4'b0000, 1'b1);
        @(negedge clk);
        checkOutput("singleDropValid", 32'(outValid), 0);
        tick();
        @(negedge clk);
        checkOutput("singleIdleBusy", 32'(busy), 0);
        checkOutput("singleIdleGrant", 32'(grant), 0);
        checkOutput("singleIdleSel", 32'(sel), 1);

        // Full contention: rotating bursts of four with no bubble.
        applyReset();
        applyStimulus(4'b1111, 1'b1);
        pushExp(4'b0001, 4); pushExp(4'b0010, 4); pushExp(4'b0100, 4);
        pushExp(4'b1000, 4); pushExp(4'b0001, 4);
        for (int i = 0; i < 20; i++) begin
            tick();
            @(negedge clk);
            checkOutput("contBusy", 32'(busy), 1);
        end
        tick();
        checkOutput("contNextGrant", 32'(grant), 4'b0010);
        applyStimulus(4'b0000, 1'b1);
        tick();
        tick();
        checkOutput("contIdle", 32'(busy), 0);

        // Backpressure: count frozen while out_ready is low.
        applyReset();
        applyStimulus(4'b0101, 1'b1);
        pushExp(4'b0001, 4);
        tick();
        @(negedge clk);
        tick();
        applyStimulus(4'b0101, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("bpGrant", 32'(grant), 4'b0001);
            checkOutput("bpInReady", 32'(inReady), 0);
            checkOutput("bpOutValid", 32'(outValid), 1);
            checkOutput("bpBeat", 32'(dut.beat_q), 1);
            tick();
        end
        applyStimulus(4'b0101, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("bpResumeBusy", 32'(busy), 1);
            tick();
        end
        applyStimulus(4'b0000, 1'b1);
        @(negedge clk);
        checkOutput("bpRegrant", 32'(grant), 4'b0100);
        checkOutput("bpRegrantSel", 32'(sel), 1);
        tick();

        // Early drop: channel 1 loses valid after two transfers, channel 3 takes over.
        applyReset();
        applyStimulus(4'b1010, 1'b1);
        pushExp(4'b0010, 2);
        pushExp(4'b1000, 1);
        tick();
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        applyStimulus(4'b1000, 1'b1);
        @(negedge clk);
        checkOutput("dropOutValid", 32'(outValid), 0);
        checkOutput("dropGrantHeld", 32'(grant), 4'b0010);
        tick();
        checkOutput("dropGrant", 32'(grant), 4'b1000);
        checkOutput("dropSel", 32'(sel), 0);
        checkOutput("dropPtr", 32'(dut.ptr_q), 2);
        @(negedge clk);
        tick();
        applyStimulus(4'b0000, 1'b1);
        tick();
        tick();

        // MAX_BURST=1: grant alternates between channels 0 and 2 every transfer.
        applyReset();
        inValid1  = 4'b0101;
        outReady1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expQ1.push_back(4'b0001);
            expQ1.push_back(4'b0100);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            @(negedge clk);
            checkOutput("mb1Busy", 32'(busy1), 1);
        end
        tick();
        inValid1 = 4'b0000;
        tick();
        tick();
        checkOutput("mb1Idle", 32'(busy1), 0);

        // Asynchronous reset in the middle of a burst, then a fresh grant.
        applyReset();
        applyStimulus(4'b0001, 1'b1);
        pushExp(4'b0001, 2);
        tick();
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        checkOutput("midBeat", 32'(dut.beat_q), 2);
        rst_n = 1'b0;
        #1;
        checkOutput("midRstGrant", 32'(grant), 0);
        checkOutput("midRstSel", 32'(sel), 3);
        checkOutput("midRstOutValid", 32'(outValid), 0);
        checkOutput("midRstBusy", 32'(busy), 0);
        applyStimulus(4'b0010, 1'b1);
        tick();
        rst_n = 1'b1;
        pushExp(4'b0010, 1);
        tick();
        @(negedge clk);
        checkOutput("postRstGrant", 32'(grant), 4'b0010);
        checkOutput("postRstSel", 32'(sel), 2);
        tick();
        applyStimulus(4'b0000, 1'b1);
        tick();
        tick();

        checkOutput("queueDrained", 32'(expQ.size()), 0);
        checkOutput("queue1Drained", 32'(expQ1.size()), 0);
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
